// File: rtl/cv32e40s_mul_arbiter.sv
// Shares one multiplier between two requesters: accept, capture operands, drive the multiplier, return the result.
// Define CV32E40S_MUL_ARB_RR_EN for round-robin selection; the default is fixed priority to requester 0.

package cv32e40s_mul_arbiter_pkg;
    typedef enum logic [0:0] {MUL_M32 = 1'b0, MUL_H = 1'b1} mul_opcode_e;
endpackage

module cv32e40s_mul_arbiter
    import cv32e40s_mul_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  mul_opcode_e req0_operator_i,
    input  logic [1:0]  req0_signed_mode_i,
    input  logic [31:0] req0_op_a_i,
    input  logic [31:0] req0_op_b_i,
    input  logic        req0_kill_i,
    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic [31:0] rsp0_result_o,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  mul_opcode_e req1_operator_i,
    input  logic [1:0]  req1_signed_mode_i,
    input  logic [31:0] req1_op_a_i,
    input  logic [31:0] req1_op_b_i,
    input  logic        req1_kill_i,
    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp1_result_o,
    output logic        mul_valid_o,
    output mul_opcode_e mul_operator_o,
    output logic [1:0]  mul_signed_mode_o,
    output logic [31:0] mul_op_a_o,
    output logic [31:0] mul_op_b_o,
    input  logic [31:0] mul_result_i,
    input  logic        mul_valid_i,
    input  logic        mul_ready_i,
    output logic        mul_ready_o
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e      state_r;
    logic        owner_r;
    logic        last_grant_r;
    mul_opcode_e operator_r;
    logic [1:0]  signed_mode_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;

    logic elig0_s;
    logic elig1_s;
    logic win1_s;
    logic grant_s;
    logic owner_kill_s;
    logic owner_rsp_ready_s;
    logic done_s;
    logic unused_mul_ready_s;

    // The multiplier's own ready is implied by it being idle whenever this block is idle.
    assign unused_mul_ready_s = mul_ready_i;

    assign mul_operator_o    = operator_r;
    assign mul_signed_mode_o = signed_mode_r;
    assign mul_op_a_o        = op_a_r;
    assign mul_op_b_o        = op_b_r;
    assign rsp0_result_o     = mul_result_i;
    assign rsp1_result_o     = mul_result_i;

    // Selection, handshakes and completion, all decided from current-cycle inputs.
    always_comb begin
        elig0_s           = req0_valid_i && !req0_kill_i;
        elig1_s           = req1_valid_i && !req1_kill_i;
`ifdef CV32E40S_MUL_ARB_RR_EN
        win1_s            = elig1_s && (!elig0_s || !last_grant_r);
`else
        win1_s            = elig1_s && !elig0_s;
`endif
        owner_kill_s      = owner_r ? req1_kill_i  : req0_kill_i;
        owner_rsp_ready_s = owner_r ? rsp1_ready_i : rsp0_ready_i;
        grant_s           = 1'b0;
        req0_ready_o      = 1'b0;
        req1_ready_o      = 1'b0;
        mul_valid_o       = 1'b0;
        mul_ready_o       = 1'b0;
        rsp0_valid_o      = 1'b0;
        rsp1_valid_o      = 1'b0;
        done_s            = 1'b0;
        if (state_r == IDLE) begin
            grant_s      = elig0_s || elig1_s;
            req0_ready_o = elig0_s && !win1_s;
            req1_ready_o = win1_s;
        end else begin
            mul_valid_o  = !owner_kill_s;
            mul_ready_o  = owner_rsp_ready_s;
            // A kill in the completion cycle suppresses the response handshake.
            rsp0_valid_o = mul_valid_i && !owner_kill_s && !owner_r;
            rsp1_valid_o = mul_valid_i && !owner_kill_s && owner_r;
            done_s       = owner_kill_s || (mul_valid_i && owner_rsp_ready_s);
        end
    end

    // State, ownership and operand capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            owner_r       <= 1'b0;
            last_grant_r  <= 1'b1;
            operator_r    <= MUL_M32;
            signed_mode_r <= 2'b00;
            op_a_r        <= 32'h0000_0000;
            op_b_r        <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r       <= BUSY;
                        owner_r       <= win1_s;
                        last_grant_r  <= win1_s;
                        operator_r    <= win1_s ? req1_operator_i    : req0_operator_i;
                        signed_mode_r <= win1_s ? req1_signed_mode_i : req0_signed_mode_i;
                        op_a_r        <= win1_s ? req1_op_a_i        : req0_op_a_i;
                        op_b_r        <= win1_s ? req1_op_b_i        : req0_op_b_i;
                    end
                end
                BUSY: begin
                    if (done_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40s_mul_arbiter.sv
// Directed bench for cv32e40s_mul_arbiter with a behavioural 1/4-cycle multiplier model.
module tb_cv32e40s_mul_arbiter;
    import cv32e40s_mul_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid_i, req0_ready_o, req0_kill_i, rsp0_valid_o, rsp0_ready_i;
    logic        req1_valid_i, req1_ready_o, req1_kill_i, rsp1_valid_o, rsp1_ready_i;
    mul_opcode_e req0_operator_i, req1_operator_i, mul_operator_o;
    logic [1:0]  req0_signed_mode_i, req1_signed_mode_i, mul_signed_mode_o;
    logic [31:0] req0_op_a_i, req0_op_b_i, req1_op_a_i, req1_op_b_i;
    logic [31:0] rsp0_result_o, rsp1_result_o, mul_op_a_o, mul_op_b_o, mul_result_i;
    logic        mul_valid_o, mul_valid_i, mul_ready_i, mul_ready_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    cv32e40s_mul_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_operator_i(req0_operator_i),
        .req0_signed_mode_i(req0_signed_mode_i), .req0_op_a_i(req0_op_a_i), .req0_op_b_i(req0_op_b_i),
        .req0_kill_i(req0_kill_i), .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp0_result_o(rsp0_result_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_operator_i(req1_operator_i),
        .req1_signed_mode_i(req1_signed_mode_i), .req1_op_a_i(req1_op_a_i), .req1_op_b_i(req1_op_b_i),
        .req1_kill_i(req1_kill_i), .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
        .rsp1_result_o(rsp1_result_o),
        .mul_valid_o(mul_valid_o), .mul_operator_o(mul_operator_o), .mul_signed_mode_o(mul_signed_mode_o),
        .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o), .mul_result_i(mul_result_i),
        .mul_valid_i(mul_valid_i), .mul_ready_i(mul_ready_i), .mul_ready_o(mul_ready_o)
    );

    // Multiplier model: MUL_M32 answers in the first valid cycle, MUL_H after four; valid_i=0 restarts it.
    logic [1:0]  step_r;
    logic [63:0] ext_a_s, ext_b_s, prod_s;
    always_ff @(posedge clk) begin
        if (!rst_n || !mul_valid_o || (mul_valid_i && mul_ready_o)) step_r <= 2'd0;
        else if (step_r != 2'd3) step_r <= step_r + 2'd1;
        else step_r <= step_r;
    end
    always_comb begin
        ext_a_s = (mul_signed_mode_o == 2'b11) ? {32'h0, mul_op_a_o} : {{32{mul_op_a_o[31]}}, mul_op_a_o};
        ext_b_s = (mul_signed_mode_o == 2'b00) ? {{32{mul_op_b_o[31]}}, mul_op_b_o} : {32'h0, mul_op_b_o};
        prod_s  = ext_a_s * ext_b_s;
    end
    assign mul_result_i = (mul_operator_o == MUL_M32) ? prod_s[31:0] : prod_s[63:32];
    assign mul_valid_i  = mul_valid_o && ((mul_operator_o == MUL_M32) || (step_r == 2'd3));
    assign mul_ready_i  = (step_r == 2'd0);

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_req(input int n, input mul_opcode_e op, input logic [1:0] mode,
                             input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            req0_valid_i = 1'b1; req0_operator_i = op; req0_signed_mode_i = mode;
            req0_op_a_i = a; req0_op_b_i = b;
        end else begin
            req1_valid_i = 1'b1; req1_operator_i = op; req1_signed_mode_i = mode;
            req1_op_a_i = a; req1_op_b_i = b;
        end
    endtask

    initial begin
        int exp_w;
        rst_n = 1'b0;
        req0_valid_i = 1'b0; req0_kill_i = 1'b0; rsp0_ready_i = 1'b1;
        req1_valid_i = 1'b0; req1_kill_i = 1'b0; rsp1_ready_i = 1'b1;
        req0_operator_i = MUL_M32; req0_signed_mode_i = 2'b00; req0_op_a_i = 32'h0; req0_op_b_i = 32'h0;
        req1_operator_i = MUL_M32; req1_signed_mode_i = 2'b00; req1_op_a_i = 32'h0; req1_op_b_i = 32'h0;
        tick(); tick();
        settle();
        chk_vec("rst_mul_valid", {31'h0, mul_valid_o}, 32'h0);
        chk_vec("rst_mul_ready", {31'h0, mul_ready_o}, 32'h0);
        chk_vec("rst_rsp_valid", {30'h0, rsp1_valid_o, rsp0_valid_o}, 32'h0);
        chk_vec("rst_op_a", mul_op_a_o, 32'h0);
        tick();
        rst_n = 1'b1;

        // M32 on requester 0: accept at T, response at T+1, idle at T+2.
        drive_req(0, MUL_M32, 2'b00, 32'h0000_0003, 32'hFFFF_FFFE);
        settle();
        chk_vec("m32_accept", {30'h0, req1_ready_o, req0_ready_o}, 32'h1);
        tick();
        settle();
        chk_vec("m32_rsp_valid", {30'h0, rsp1_valid_o, rsp0_valid_o}, 32'h1);
        chk_vec("m32_result", rsp0_result_o, 32'hFFFF_FFFA);
        chk_vec("m32_no_b2b_accept", {31'h0, req0_ready_o}, 32'h0);
        tick();
        req0_valid_i = 1'b0;
        settle();
        chk_vec("m32_idle", {30'h0, mul_valid_o, rsp0_valid_o}, 32'h0);
        tick();

        // MULH on requester 1: response at T+4.
        drive_req(1, MUL_H, 2'b00, 32'h8000_0000, 32'h8000_0000);
        settle();
        chk_vec("mulh_accept", {30'h0, req1_ready_o, req0_ready_o}, 32'h2);
        tick();
        req1_valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk_vec("mulh_rsp0_quiet", {31'h0, rsp0_valid_o}, 32'h0);
            chk_vec("mulh_rsp1_valid", {31'h0, rsp1_valid_o}, (k == 4) ? 32'h1 : 32'h0);
            if (k == 4) chk_vec("mulh_result", rsp1_result_o, 32'h4000_0000);
            tick();
        end

        // Contention: both requesters valid every cycle.
        drive_req(0, MUL_M32, 2'b00, 32'd2, 32'd5);
        drive_req(1, MUL_M32, 2'b00, 32'd7, 32'd3);
        for (int g = 0; g < 4; g++) begin
            settle();
`ifdef CV32E40S_MUL_ARB_RR_EN
            exp_w = g % 2;
`else
            exp_w = 0;
`endif
            chk_vec("arb_grant", {30'h0, req1_ready_o, req0_ready_o}, (exp_w == 1) ? 32'h2 : 32'h1);
            tick();
            settle();
            if (exp_w == 1) chk_vec("arb_rsp1", rsp1_valid_o ? rsp1_result_o : 32'hDEAD_BEEF, 32'd21);
            else chk_vec("arb_rsp0", rsp0_valid_o ? rsp0_result_o : 32'hDEAD_BEEF, 32'd10);
            tick();
        end
        // A killed requester is not eligible in IDLE.
        req0_kill_i = 1'b1;
        settle();
        chk_vec("kill_masks_idle", {30'h0, req1_ready_o, req0_ready_o}, 32'h2);
        tick();
        req0_kill_i = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        tick();

        // Kill of the owner mid MULH, then a fresh MULHSU on the same requester.
        drive_req(0, MUL_H, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        req0_valid_i = 1'b0;
        settle();
        chk_vec("kill_busy_valid", {31'h0, mul_valid_o}, 32'h1);
        tick();
        req0_kill_i = 1'b1;
        settle();
        chk_vec("kill_mul_valid", {31'h0, mul_valid_o}, 32'h0);
        chk_vec("kill_no_rsp", {31'h0, rsp0_valid_o}, 32'h0);
        tick();
        req0_kill_i = 1'b0;
        drive_req(0, MUL_H, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        settle();
        chk_vec("kill_regrant", {31'h0, req0_ready_o}, 32'h1);
        tick();
        req0_valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk_vec("kill_rerun_valid", {31'h0, rsp0_valid_o}, (k == 4) ? 32'h1 : 32'h0);
            if (k == 4) chk_vec("kill_rerun_result", rsp0_result_o, 32'hFFFF_FFFF);
            tick();
        end

        // Response backpressure for 5 cycles.
        drive_req(0, MUL_M32, 2'b00, 32'h0000_0010, 32'h0000_0010);
        tick();
        req0_valid_i = 1'b0;
        rsp0_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk_vec("bp_valid", {30'h0, mul_ready_o, rsp0_valid_o}, 32'h1);
            chk_vec("bp_result", rsp0_result_o, 32'h0000_0100);
            tick();
        end
        rsp0_ready_i = 1'b1;
        settle();
        chk_vec("bp_complete", {30'h0, mul_ready_o, rsp0_valid_o}, 32'h3);
        tick();
        settle();
        chk_vec("bp_idle", {31'h0, rsp0_valid_o}, 32'h0);
        tick();

        // Reset during a MULH operation.
        drive_req(1, MUL_H, 2'b00, 32'h1234_5678, 32'h0000_0003);
        tick();
        req1_valid_i = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk_vec("rst_busy_mul_valid", {31'h0, mul_valid_o}, 32'h0);
        chk_vec("rst_busy_rsp", {30'h0, rsp1_valid_o, rsp0_valid_o}, 32'h0);
        chk_vec("rst_busy_op_a", mul_op_a_o, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            settle();
            chk_vec("rst_no_late_rsp", {29'h0, mul_valid_o, rsp1_valid_o, rsp0_valid_o}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
